// File: rtl/mem_seq_player.sv
`default_nettype none
// ============================================================================
//  Module   : mem_seq_player
//  Purpose  : Record/playback sequencer in front of a 32x8 memory with a
//             1-cycle registered read. Record mode appends bytes at
//             consecutive addresses. Playback mode reads them back in order
//             and offers each byte to a consumer over valid/ready.
//  Options  : MEM_SEQ_LOOP_EN - adds i_loop. When it is high at the last
//             byte, playback wraps to address 0 instead of finishing.
//  Ports    :
//    i_Clk, i_Rst_L           clock, synchronous active-low reset
//    i_rec_valid/i_rec_data   record byte offered
//    o_rec_ready              record byte accepted (with i_rec_valid)
//    i_clear                  discard recorded sequence
//    i_start                  start playback (honoured in IDLE only)
//    i_abort                  abandon playback
//    i_loop                   (MEM_SEQ_LOOP_EN only) loop playback
//    o_mem_write_*            memory write port
//    o_mem_read_en/addr       memory read port request
//    i_mem_read_data          memory read data, one cycle after request
//    o_data/o_valid/i_ready   playback byte handshake
//    o_busy, o_done, o_count  status
//  Revision : 1.0 - initial release
// ============================================================================
module mem_seq_player #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_rec_valid,
    input  logic [DATA_W-1:0] i_rec_data,
    output logic              o_rec_ready,
    input  logic              i_clear,
    input  logic              i_start,
    input  logic              i_abort,
`ifdef MEM_SEQ_LOOP_EN
    input  logic              i_loop,
`endif
    output logic              o_mem_write_en,
    output logic [ADDR_W-1:0] o_mem_write_addr,
    output logic [DATA_W-1:0] o_mem_write_data,
    output logic              o_mem_read_en,
    output logic [ADDR_W-1:0] o_mem_read_addr,
    input  logic [DATA_W-1:0] i_mem_read_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W:0]   o_count
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_PRESENT = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [ADDR_W:0]   c_full    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_cnt_one = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);

    logic [2:0]        r_state;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    logic w_idle;
    logic w_rec_ready;
    logic w_write;
    logic w_last;
    logic w_loop;

`ifdef MEM_SEQ_LOOP_EN
    assign w_loop = i_loop;
`else
    assign w_loop = 1'b0;
`endif

    assign w_idle = (r_state == ST_IDLE);

    // Recording is only accepted in IDLE when neither start nor clear claims
    // the cycle. Gated by reset so nothing is written while reset is held.
    assign w_rec_ready = i_Rst_L & w_idle & (r_count < c_full) & ~i_start & ~i_clear;
    assign w_write     = i_rec_valid & w_rec_ready;

    // ptr is zero-extended against count-1; count is never 0 in PRESENT.
    assign w_last = ({1'b0, r_ptr} == (r_count - c_cnt_one));

    assign o_rec_ready      = w_rec_ready;
    assign o_mem_write_en   = w_write;
    assign o_mem_write_addr = w_write ? r_count[ADDR_W-1:0] : '0;
    assign o_mem_write_data = w_write ? i_rec_data : '0;
    assign o_mem_read_en    = (r_state == ST_REQ);
    assign o_mem_read_addr  = (r_state == ST_REQ) ? r_ptr : '0;
    assign o_data           = r_data;
    assign o_valid          = r_valid;
    assign o_busy           = ~w_idle;
    assign o_done           = (r_state == ST_DONE);
    assign o_count          = r_count;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_ptr   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_clear) begin
                        r_count <= '0;
                    end else if (i_start) begin
                        r_ptr   <= '0;
                        r_state <= (r_count != '0) ? ST_REQ : ST_DONE;
                    end else if (w_write) begin
                        r_count <= r_count + c_cnt_one;
                    end
                end
                ST_REQ: begin
                    r_state <= i_abort ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    // Read data from the REQ cycle is valid here.
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_data  <= i_mem_read_data;
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (i_abort) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (i_ready) begin
                        r_valid <= 1'b0;
                        if (w_last) begin
                            if (w_loop) begin
                                r_ptr   <= '0;
                                r_state <= ST_REQ;
                            end else begin
                                r_state <= ST_DONE;
                            end
                        end else begin
                            r_ptr   <= r_ptr + c_ptr_one;
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_seq_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_seq_player
//  Purpose  : Self-checking bench for mem_seq_player with a behavioural
//             32x8 memory and a byte-queue reference of the recorded sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_seq_player;

    logic       clk = 1'b0;
    logic       i_Rst_L;
    logic       i_rec_valid;
    logic [7:0] i_rec_data;
    logic       o_rec_ready;
    logic       i_clear;
    logic       i_start;
    logic       i_abort;
`ifdef MEM_SEQ_LOOP_EN
    logic       i_loop;
`endif
    logic       o_mem_write_en;
    logic [4:0] o_mem_write_addr;
    logic [7:0] o_mem_write_data;
    logic       o_mem_read_en;
    logic [4:0] o_mem_read_addr;
    logic [7:0] i_mem_read_data;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_busy;
    logic       o_done;
    logic [5:0] o_count;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] model_q [$];
    logic [7:0] mem [32];
    bit loop_on = 1'b0;

    always #5 clk = ~clk;

    mem_seq_player dut (
        .i_Clk            (clk),
        .i_Rst_L          (i_Rst_L),
        .i_rec_valid      (i_rec_valid),
        .i_rec_data       (i_rec_data),
        .o_rec_ready      (o_rec_ready),
        .i_clear          (i_clear),
        .i_start          (i_start),
        .i_abort          (i_abort),
`ifdef MEM_SEQ_LOOP_EN
        .i_loop           (i_loop),
`endif
        .o_mem_write_en   (o_mem_write_en),
        .o_mem_write_addr (o_mem_write_addr),
        .o_mem_write_data (o_mem_write_data),
        .o_mem_read_en    (o_mem_read_en),
        .o_mem_read_addr  (o_mem_read_addr),
        .i_mem_read_data  (i_mem_read_data),
        .o_data           (o_data),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_count          (o_count)
    );

    // Behavioural memory: registered read, one cycle latency.
    always @(posedge clk) begin
        if (o_mem_write_en) mem[o_mem_write_addr] <= o_mem_write_data;
        if (o_mem_read_en)  i_mem_read_data <= mem[o_mem_read_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rec(input logic [7:0] b);
        logic exp_rdy;
        exp_rdy = (model_q.size() < 32);
        i_rec_valid = 1'b1;
        i_rec_data  = b;
        #1;
        chk("rec_ready", o_rec_ready, exp_rdy);
        chk("rec_wr_en", o_mem_write_en, exp_rdy);
        if (exp_rdy) begin
            chk("rec_wr_addr", o_mem_write_addr, model_q.size());
            chk("rec_wr_data", o_mem_write_data, b);
        end
        tick;
        if (exp_rdy) model_q.push_back(b);
    endtask

    task automatic clear_seq;
        i_clear = 1'b1;
        i_rec_valid = 1'b1;
        #1;
        chk("clear_rec_ready", o_rec_ready, 0);
        chk("clear_no_write", o_mem_write_en, 0);
        tick;
        i_clear = 1'b0;
        i_rec_valid = 1'b0;
        model_q.delete();
        chk("clear_count", o_count, 0);
    endtask

    // Plays 'total' bytes; byte k is the recorded byte k mod size.
    // stall < 0 picks a random 0..3 cycle consumer stall per byte.
    task automatic play(input int total, input int stall);
        int n;
        n = model_q.size();
        i_start = 1'b1;
        #1;
        chk("start_rec_ready", o_rec_ready, 0);
        tick;
        i_start = 1'b0;
        for (int k = 0; k < total; k++) begin
            int a;
            int s;
            a = k % n;
            chk("req_rd_en", o_mem_read_en, 1);
            chk("req_rd_addr", o_mem_read_addr, a);
            chk("req_valid", o_valid, 0);
            chk("req_busy", o_busy, 1);
            i_rec_valid = 1'($urandom % 2);
            i_start     = 1'($urandom % 2);
            #1;
            chk("busy_no_write", o_mem_write_en, 0);
            tick;
            i_rec_valid = 1'b0;
            i_start     = 1'b0;
            chk("wait_rd_en", o_mem_read_en, 0);
            chk("wait_valid", o_valid, 0);
            tick;
            chk("pres_valid", o_valid, 1);
            chk("pres_data", o_data, model_q[a]);
            s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            repeat (s) begin
                tick;
                chk("stall_rd_en", o_mem_read_en, 0);
                chk("stall_valid", o_valid, 1);
                chk("stall_data", o_data, model_q[a]);
                chk("stall_done", o_done, 0);
            end
            i_ready = 1'b1;
`ifdef MEM_SEQ_LOOP_EN
            i_loop = loop_on && (k != total - 1);
`endif
            #1;
            tick;
            i_ready = 1'b0;
            chk("acc_valid_drop", o_valid, 0);
        end
        chk("done_pulse", o_done, 1);
        chk("done_rd_en", o_mem_read_en, 0);
        i_abort = 1'($urandom % 2);
        tick;
        i_abort = 1'b0;
        chk("post_done", o_done, 0);
        chk("post_busy", o_busy, 0);
        chk("post_valid", o_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        i_Rst_L = 1'b0; i_rec_valid = 1'b0; i_rec_data = '0; i_clear = 1'b0;
        i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
`ifdef MEM_SEQ_LOOP_EN
        i_loop = 1'b0;
`endif
        tick; tick;
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_count", o_count, 0);
        chk("rst_rd_en", o_mem_read_en, 0);
        chk("rst_wr_en", o_mem_write_en, 0);
        chk("rst_data", o_data, 0);
        i_Rst_L = 1'b1;

        // Back-to-back record then zero-stall and long-stall playback
        rec(8'hA1); rec(8'hB2); rec(8'hC3);
        i_rec_valid = 1'b0;
        chk("count3", o_count, 3);
        play(3, 0);
        play(3, 5);

        // Abort in WAIT keeps the count
        i_start = 1'b1; tick; i_start = 1'b0;
        tick;
        i_abort = 1'b1; #1; tick; i_abort = 1'b0;
        chk("abort_wait_busy", o_busy, 0);
        chk("abort_wait_valid", o_valid, 0);
        chk("abort_wait_done", o_done, 0);
        chk("abort_wait_count", o_count, 3);
        tick;
        chk("abort_wait_nodone", o_done, 0);

        // Abort in PRESENT, then a normal playback still works
        i_start = 1'b1; tick; i_start = 1'b0;
        tick; tick;
        chk("abort_pres_pre", o_valid, 1);
        i_abort = 1'b1; #1; tick; i_abort = 1'b0;
        chk("abort_pres_valid", o_valid, 0);
        chk("abort_pres_busy", o_busy, 0);
        play(3, -1);

        // Reset in PRESENT
        i_start = 1'b1; tick; i_start = 1'b0;
        tick; tick;
        chk("rstp_pre_valid", o_valid, 1);
        i_Rst_L = 1'b0; #1; tick; i_Rst_L = 1'b1;
        model_q.delete();
        chk("rstp_busy", o_busy, 0);
        chk("rstp_valid", o_valid, 0);
        chk("rstp_done", o_done, 0);
        chk("rstp_count", o_count, 0);

        // Random lengths and contents
        for (int r = 0; r < 4; r++) begin
            int len;
            len = int'($urandom_range(1, 12));
            for (int j = 0; j < len; j++) rec(8'($urandom));
            i_rec_valid = 1'b0;
            chk("rand_count", o_count, model_q.size());
            play(model_q.size(), -1);
            clear_seq;
        end

        // Fill: 33 offers, 32 kept
        for (int j = 0; j < 33; j++) rec(8'($urandom));
        i_rec_valid = 1'b0;
        chk("full_count", o_count, 32);
        #1;
        chk("full_rec_ready", o_rec_ready, 0);
        play(32, -1);

        // Clear, then start with nothing recorded
        clear_seq;
        i_start = 1'b1; tick; i_start = 1'b0;
        chk("empty_done", o_done, 1);
        chk("empty_valid", o_valid, 0);
        tick;
        chk("empty_idle", o_busy, 0);
        chk("empty_valid2", o_valid, 0);

`ifdef MEM_SEQ_LOOP_EN
        rec(8'hA1); rec(8'hB2);
        i_rec_valid = 1'b0;
        loop_on = 1'b1;
        play(6, -1);
        loop_on = 1'b0;
        i_loop = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
